// File: rtl/hex_keypad_entry.sv
// Scans a 4x4 hex keypad, debounces full-scan snapshots and shifts accepted keys into a 32-bit value.
// Optional feature: define KEYPAD_BACKSPACE_EN to make key D delete the newest digit.
module hex_keypad_entry #(
    parameter int SCAN_DIV_W     = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    input  logic        clear,
    output logic [31:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [3:0]  digit_count
);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS);

    logic [SCAN_DIV_W+1:0] scan_q;
    logic [3:0]            col_meta_q, col_sync_q;
    logic [11:0]           snap_q;
    state_t                state_q, state_d;
    logic [3:0]            cand_q, cand_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           value_q;
    logic [3:0]            key_code_q, digit_count_q;
    logic                  key_valid_q;

    logic [1:0]  row_sel;
    logic        last_dwell, scan_done;
    logic [15:0] snap_full;
    logic [1:0]  n_set;
    logic [3:0]  key_idx, key_k;
    logic        is_empty, is_single;
    logic        accept;
    logic [3:0]  accept_code;

    assign row_sel    = scan_q[SCAN_DIV_W+1:SCAN_DIV_W];
    assign last_dwell = &scan_q[SCAN_DIV_W-1:0];
    assign scan_done  = last_dwell && (row_sel == 2'd3);
    assign row        = ~(4'b0001 << row_sel);

    // Row 3 is being captured in the scan_done cycle itself, so it comes straight from the synchronizer.
    assign snap_full = {~col_sync_q, snap_q};

    always_comb begin
        n_set   = 2'd0;
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                if (n_set != 2'd2) n_set = n_set + 2'd1;
                key_idx = 4'(i);
            end
        end
    end

    assign is_empty  = (n_set == 2'd0);
    assign is_single = (n_set == 2'd1);

    always_comb begin
        case (key_idx)
            4'd0:  key_k = 4'h1;
            4'd1:  key_k = 4'h2;
            4'd2:  key_k = 4'h3;
            4'd3:  key_k = 4'hA;
            4'd4:  key_k = 4'h4;
            4'd5:  key_k = 4'h5;
            4'd6:  key_k = 4'h6;
            4'd7:  key_k = 4'hB;
            4'd8:  key_k = 4'h7;
            4'd9:  key_k = 4'h8;
            4'd10: key_k = 4'h9;
            4'd11: key_k = 4'hC;
            4'd12: key_k = 4'hE;
            4'd13: key_k = 4'h0;
            4'd14: key_k = 4'hF;
            default: key_k = 4'hD;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        accept_code = cand_q;
        if (scan_done) begin
            case (state_q)
                IDLE: if (is_single) begin
                    cand_d      = key_k;
                    cnt_d       = 4'd1;
                    accept_code = key_k;
                    if (DEBOUNCE_SCANS == 1) begin
                        accept  = 1'b1;
                        state_d = HELD;
                    end else begin
                        state_d = PRESS_DB;
                    end
                end
                PRESS_DB: if (is_single && key_k == cand_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == DB_LAST) begin
                        accept  = 1'b1;
                        state_d = HELD;
                    end
                end else begin
                    state_d = IDLE;
                end
                HELD: if (is_empty) begin
                    cnt_d   = 4'd1;
                    state_d = (DEBOUNCE_SCANS == 1) ? IDLE : REL_DB;
                end
                default: if (is_empty) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == DB_LAST) state_d = IDLE;
                end else begin
                    state_d = HELD;
                end
            endcase
        end
    end

    // NOTE: every register here uses non-blocking assignment and clears asynchronously on rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_q      <= '0;
            col_meta_q  <= 4'hF;
            col_sync_q  <= 4'hF;
            snap_q      <= '0;
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
        end else begin
            scan_q     <= scan_q + 1'b1;
            col_meta_q <= col;
            col_sync_q <= col_meta_q;
            if (last_dwell && row_sel != 2'd3) snap_q[4*row_sel +: 4] <= ~col_sync_q;
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q       <= '0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            digit_count_q <= 4'd0;
        end else begin
            key_valid_q <= accept;
            if (accept) key_code_q <= accept_code;
            if (clear) begin
                value_q       <= '0;
                digit_count_q <= 4'd0;
            end else if (accept) begin
`ifdef KEYPAD_BACKSPACE_EN
                if (accept_code == 4'hD) begin
                    value_q <= {4'h0, value_q[31:4]};
                    if (digit_count_q != 4'd0) digit_count_q <= digit_count_q - 4'd1;
                end else begin
                    value_q <= {value_q[27:0], accept_code};
                    if (digit_count_q != 4'd8) digit_count_q <= digit_count_q + 4'd1;
                end
`else
                value_q <= {value_q[27:0], accept_code};
                if (digit_count_q != 4'd8) digit_count_q <= digit_count_q + 4'd1;
`endif
            end
        end
    end

    assign value       = value_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign digit_count = digit_count_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a behavioural keypad (SCAN_DIV_W=2, DEBOUNCE_SCANS=3).
module tb_hex_keypad_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clear = 1'b0;
    logic [31:0] value;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [3:0]  digit_count;

    logic [15:0] keys = '0;       // pressed-key mask, bit 4*r+c
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic [3:0]  last_code = 4'd0;
    int unsigned tb_cnt = 0;      // edges since reset release, for scan-phase alignment

    hex_keypad_entry #(.SCAN_DIV_W(2), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .clear(clear),
        .value(value), .key_code(key_code), .key_valid(key_valid), .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row[r]) col = col & ~keys[4*r +: 4];
    end

    always @(posedge clk or negedge rst)
        if (!rst) tb_cnt <= 0;
        else      tb_cnt <= tb_cnt + 1;

    always @(negedge clk)
        if (key_valid) begin
            pulses    = pulses + 1;
            last_code = key_code;
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scans(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    task automatic enter(input int idx);
        keys = 16'(1) << idx;
        scans(6);
        keys = '0;
        scans(4);
    endtask

    task automatic do_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    int n;
    int p0;

    initial begin
        // Power-on reset
        #23;
        check("por_row", 32'(row), 32'h0000000E);
        check("por_value", value, 32'h0);
        check("por_key_code", 32'(key_code), 32'h0);
        check("por_digit_count", 32'(digit_count), 32'h0);
        @(negedge clk) rst = 1'b1;

        // Hold '5' until it is accepted, then reset mid-scan with the key still down
        keys = 16'(1) << 5;
        n = 0;
        while (pulses == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_accept_seen", 32'(pulses), 32'd1);
        check("pre_reset_value", value, 32'h5);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_row", 32'(row), 32'h0000000E);
        check("rst_value", value, 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_digit_count", 32'(digit_count), 32'h0);
        @(negedge clk) rst = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!key_valid && n < 100);
        check("rst_accept_latency_ok", 32'(n >= 48 && n <= 64), 32'd1);
        keys = '0;
        scans(4);

        // Single key after clear
        do_clear();
        check("clear_value", value, 32'h0);
        check("clear_digit_count", 32'(digit_count), 32'h0);
        p0 = pulses;
        enter(5);
        check("single_pulses", 32'(pulses - p0), 32'd1);
        check("single_code", 32'(last_code), 32'h5);
        check("single_value", value, 32'h00000005);
        check("single_digit_count", 32'(digit_count), 32'd1);

        // Overflow with nine digits
        do_clear();
        p0 = pulses;
        enter(0); enter(1); enter(2); enter(4); enter(5);
        enter(6); enter(8); enter(9); enter(10);
        check("ovf_pulses", 32'(pulses - p0), 32'd9);
        check("ovf_value", value, 32'h23456789);
        check("ovf_digit_count", 32'(digit_count), 32'd8);

        // Short bounce on '7'
        p0 = pulses;
        keys = 16'(1) << 8;
        scans(2);
        keys = '0;
        scans(4);
        check("bounce_no_pulse", 32'(pulses - p0), 32'd0);

        // '1' and '2' together
        keys = 16'h0003;
        scans(6);
        keys = '0;
        scans(4);
        check("multi_no_pulse", 32'(pulses - p0), 32'd0);
        check("multi_value_kept", value, 32'h23456789);

        // '3' accepted, then '4' added while '3' still held
        p0 = pulses;
        keys = 16'(1) << 2;
        scans(6);
        keys = keys | (16'(1) << 4);
        scans(4);
        keys = '0;
        scans(4);
        check("held_one_pulse", 32'(pulses - p0), 32'd1);
        check("held_code", 32'(last_code), 32'h3);

        // Clear coinciding with the accept of '9'
        do_clear();
        enter(0);
        enter(1);
        check("pre_collision_value", value, 32'h00000012);
        do @(negedge clk); while (tb_cnt[3:0] != 4'd0);
        keys = 16'(1) << 10;
        repeat (47) @(negedge clk);
        clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        check("collision_key_valid", 32'(key_valid), 32'd1);
        check("collision_key_code", 32'(key_code), 32'h9);
        check("collision_value", value, 32'h0);
        check("collision_digit_count", 32'(digit_count), 32'd0);
        keys = '0;
        scans(4);

        // Key D: backspace or plain digit depending on build
        do_clear();
        enter(0); enter(1); enter(2);
        check("pre_d_value", value, 32'h00000123);
        check("pre_d_digit_count", 32'(digit_count), 32'd3);
        p0 = pulses;
        enter(15);
        check("d_pulse", 32'(pulses - p0), 32'd1);
        check("d_code", 32'(last_code), 32'hD);
`ifdef KEYPAD_BACKSPACE_EN
        check("d_value", value, 32'h00000012);
        check("d_digit_count", 32'(digit_count), 32'd2);
`else
        check("d_value", value, 32'h0000123D);
        check("d_digit_count", 32'(digit_count), 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_keypad_entry.md
Name: hex_keypad_entry

Overview:
- Scans a 4x4 matrix hex keypad, debounces it, and assembles accepted keys into a 32-bit hex value, one nibble per key.
- This is the input-side counterpart of the multiplexed 7-segment display driver. It time-multiplexes row drives and reads columns, where the display driver multiplexes anodes.
- `value` connects directly to the display driver's 32-bit `display` input, so entered digits scroll in from the right.

Parameters:
- SCAN_DIV_W, 16: row dwell is 2^SCAN_DIV_W clk cycles. Must be >= 2. One full scan is 4*2^SCAN_DIV_W cycles.
- DEBOUNCE_SCANS, 4: number of consecutive identical full-scan snapshots needed to accept a press or a release. Range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- row  output  4  row drive, active-low one-hot
- col  input  4  column sense, active-low (external pull-ups), asynchronous to clk
- clear  input  1  synchronous single-cycle clear of the entered value
- value  output  32  entered hex value, newest key in [3:0]
- key_code  output  4  code of the last accepted key
- key_valid  output  1  one-cycle pulse per accepted key
- digit_count  output  4  number of valid nibbles in `value`, 0..8

Behaviour:
- Reset values (rst=0, takes effect immediately): row=4'b1110, value=0, key_code=0, key_valid=0, digit_count=0, FSM=IDLE, scan counter=0, synchronizer=4'b1111, debounce count=0.
- A mid-operation reset aborts everything. After release of reset the scan restarts at row0.

Scanning:
- Free-running counter of width SCAN_DIV_W+2. Its top 2 bits select the row r, and `row` = ~(1<<r).
- col passes through a 2-flop synchronizer.
- On the last cycle of each row dwell, ~col_sync is stored into snapshot bits [4r+3:4r].
- scan_done is asserted on the last cycle of row3's dwell. The snapshot is evaluated in that cycle.

Key map (row r, col c -> code):
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: E 0 F D

Snapshot classes:
- EMPTY: no bits set.
- SINGLE(k): exactly one bit set, giving key k.
- MULTI: more than one bit set.

FSM (transitions evaluated only on scan_done; cnt is the debounce counter):
- IDLE
  - SINGLE(k): cand=k, cnt=1, go to PRESS_DB. If DEBOUNCE_SCANS=1, accept and go directly to HELD.
  - Otherwise: stay.
- PRESS_DB
  - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
  - Any other class: go to IDLE.
- HELD
  - EMPTY: cnt=1, go to REL_DB. If DEBOUNCE_SCANS=1, go directly to IDLE.
  - Otherwise (including MULTI or a different key): stay. No repeat and no second accept.
- REL_DB
  - EMPTY: cnt+1. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
  - Non-empty: go to HELD.

Accept (registered, visible the cycle after the accepting scan_done):
- key_valid=1 for exactly one cycle.
- key_code=cand.
- value <= {value[27:0], cand}.
- digit_count <= min(digit_count+1, 8). The oldest nibble is discarded once 8 digits are present.

clear:
- clear=1 sets value=0 and digit_count=0 on the next edge.
- If clear coincides with an accept update, clear wins for value and digit_count. key_valid and key_code still update.
- clear does not affect the FSM or the scan.

Optional Feature:
- Macro: KEYPAD_BACKSPACE_EN.
- Defined: an accepted key D acts as backspace.
  - value <= {4'h0, value[31:4]}.
  - digit_count <= max(digit_count-1, 0).
  - key_valid pulses and key_code=4'hD as normal.
- Undefined: D shifts in like any other hex digit.

Test Plan:
All scenarios use SCAN_DIV_W=2 and DEBOUNCE_SCANS=3, giving a 16-cycle scan.
- Reset: assert rst=0 mid-scan with a key held -> row=4'b1110, value=0, key_valid=0, digit_count=0. After release, the first accept occurs no earlier than the end of the 3rd full scan.
- Single key: hold r1c1 ('5') for 6 scans, then release for 4 scans -> exactly one key_valid pulse, key_code=5, value=32'h00000005, digit_count=1.
- Overflow: enter 1,2,3,4,5,6,7,8,9 with clean press/release each -> value=32'h23456789, digit_count=8, nine key_valid pulses.
- Bounce and multi-key:
  - Hold '7' for 2 scans, release -> no key_valid.
  - Hold '1' and '2' together for 6 scans -> no key_valid.
  - Hold '3', accept, then add '4' while '3' is still held -> only one pulse, key_code=3.
- Clear collision: value=32'h00000012; assert clear in the same cycle as the accept update for '9' -> value=0, digit_count=0, key_valid=1, key_code=9.
- Backspace (macro defined): from value=32'h00000123 and digit_count=3, press 'D' -> value=32'h00000012, digit_count=2. With the macro undefined -> value=32'h0000123D, digit_count=4.
